// File: rtl/load_store_unit.sv
// load_store_unit: single-port RAM load/store sequencer with sub-word extension
// and read-modify-write for halfword/byte stores.
module load_store_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                          LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;
   state_t state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, wword_q, wword_d;
   logic        err_q, err_d;
   logic        misaligned;
   logic [31:0] sh, load_val, lane_mask, lane_data, merged;
   assign misaligned = (op == LW || op == SW) ? |addr[1:0] :
                       (op == LH || op == LHU || op == SH) ? addr[0] : 1'b0;
   // Shifting the word right by the byte offset puts the addressed lane at bit 0.
   assign sh = mem_rdata >> {addr_q[1:0], 3'b000};
   assign load_val = op_q == LW  ? mem_rdata :
                     op_q == LH  ? {{16{sh[15]}}, sh[15:0]} :
                     op_q == LHU ? {16'b0, sh[15:0]} :
                     op_q == LB  ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
   assign lane_mask = op_q == SB ? 32'h0000_00FF << {addr_q[1:0], 3'b000} :
                      addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
   assign lane_data = op_q == SB ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
   assign merged    = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      wword_d = wword_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (start) begin
            op_d    = op;
            addr_d  = addr;
            wdata_d = wdata;
            wword_d = wdata;
            err_d   = misaligned;
            state_d = misaligned ? DONE : (op == SW ? WRITE : READ);
         end
         READ: begin
            wword_d = (op_q == SH || op_q == SB) ? merged : wword_q;
            rdata_d = (op_q == SH || op_q == SB) ? rdata_q : load_val;
            state_d = (op_q == SH || op_q == SB) ? WRITE : DONE;
         end
         WRITE: state_d = DONE;
         DONE: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wword_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         wword_q <= wword_d;
         err_q   <= err_d;
      end
   end
   assign busy      = state_q != IDLE;
   assign done      = state_q == DONE;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_read  = state_q == READ;
   assign mem_write = state_q == WRITE;
   assign mem_wdata = mem_write ? wword_q : '0;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; all widths SHALL be fixed at 32-bit address and 32-bit data.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising clk.
REQ-004 start  input  1  request strobe; accepted only in IDLE.
REQ-005 op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-006 addr  input  32  CPU byte address.
REQ-007 wdata  input  32  store data; SW uses [31:0], SH uses [15:0], SB uses [7:0].
REQ-008 busy  output  1  high whenever state != IDLE.
REQ-009 done  output  1  one-cycle pulse at completion.
REQ-010 err  output  1  valid with done; high for a misaligned request.
REQ-011 rdata  output  32  load result, extended per op; held until the next done.
REQ-012 mem_addr  output  32  word address to RAM, {addr[31:2],2'b00}.
REQ-013 mem_wdata  output  32  full word to RAM data_in.
REQ-014 mem_read  output  1  RAM read enable.
REQ-015 mem_write  output  1  RAM write enable; RAM commits the word while asserted.
REQ-016 mem_rdata  input  32  RAM data_out; combinational and little-endian (lane n = bits [8n+7:8n] = byte at word+n).

Function
REQ-017 On start in IDLE, the unit SHALL capture op, addr and wdata; later changes to those inputs SHALL NOT affect the request.
REQ-018 States SHALL be IDLE, READ, WRITE and DONE.
REQ-019 Loads SHALL follow IDLE->READ->DONE->IDLE; mem_rdata is registered at the end of READ, so done rises 2 cycles after start.
REQ-020 SW SHALL follow IDLE->WRITE->DONE->IDLE, with mem_wdata = captured wdata.
REQ-021 SH and SB SHALL read-modify-write via IDLE->READ->WRITE->DONE->IDLE, replacing only the addressed lane(s) of the read word; done rises 3 cycles after start.
REQ-022 Byte lane SHALL be addr[1:0]; halfword lane SHALL be addr[1] (bits [15:0] or [31:16]).
REQ-023 LB and LH SHALL sign-extend, LBU and LHU SHALL zero-extend, and LW SHALL return the full word.
REQ-024 A misaligned request (LW/SW with addr[1:0]!=0, LH/LHU/SH with addr[0]!=0) SHALL go IDLE->DONE with err=1, no mem_read/mem_write, and rdata unchanged.
REQ-025 mem_read SHALL be high only in READ, and mem_write only in WRITE; they SHALL never be high together.
REQ-026 mem_addr and mem_wdata SHALL be stable for the whole READ/WRITE cycle, and mem_wdata SHALL be 0 outside WRITE.
REQ-027 start SHALL be ignored while busy=1, and no request is queued.
REQ-028 start in the same cycle that DONE returns to IDLE SHALL be ignored; the earliest next acceptance is the cycle after done.
REQ-029 Stores SHALL leave rdata unchanged, and err SHALL be 0 on every non-misaligned done.

Reset
REQ-030 When reset=1, the state SHALL be IDLE and busy, done, err, mem_read and mem_write SHALL be 0 from the next edge, with rdata, mem_addr and mem_wdata = 0.
REQ-031 Reset during READ or WRITE SHALL abort the request with no done pulse, and mem_write SHALL deassert at the next edge.
REQ-032 Reset SHALL take priority over a simultaneous start.

Verification
REQ-033 RAM word 0x100 = 0x8877_6655, LB addr 0x103 -> done at start+2, rdata=0xFFFF_FF88, err=0, one mem_read cycle at mem_addr 0x100.
REQ-034 Same word, LHU addr 0x102 -> rdata=0x0000_8877; LH addr 0x100 -> rdata=0x0000_6655.
REQ-035 SB addr 0x101, wdata=0xAB -> READ then WRITE of 0x8877_AB55 to 0x100, done at start+3; a following LW addr 0x100 -> rdata=0x8877_AB55.
REQ-036 LW addr 0x102 -> done at start+1, err=1, mem_read and mem_write never asserted, rdata unchanged.
REQ-037 SH addr 0x104 started, reset asserted during WRITE -> no done pulse, busy=0 next cycle; start pulses while busy -> ignored (exactly one done per accepted start).
